// File: rtl/addr8u_serial_sub.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow = (a < b), LSB first.
// Optional self-check (err port, hold registers) enabled by defining SERSUB_CHECK_EN.
module addr8u_serial_sub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERSUB_CHECK_EN
  , output logic           err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sh, diff_q;
  logic             br, borrow_q;
  logic [CNT_W-1:0] cnt;
  logic             d, br_nxt, last;
  logic [WIDTH-1:0] sh_nxt;

  // One full-subtractor slice; sh collects result bits from the MSB side.
  always_comb begin
    d      = sa[0] ^ sb[0] ^ br;
    br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sh_nxt = {d, sh[WIDTH-1:1]};
    last   = (cnt == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready depends on state only, so there is no comb path from out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sa       <= '0;
      sb       <= '0;
      sh       <= '0;
      diff_q   <= '0;
      br       <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          sa  <= a;
          sb  <= b;
          br  <= 1'b0;
          cnt <= '0;
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sh  <= sh_nxt;
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
          // Output registers only change on DONE entry, so the last result persists.
          if (last) begin
            diff_q   <= sh_nxt;
            borrow_q <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERSUB_CHECK_EN
  logic [WIDTH-1:0] a_h, b_h;
  logic [WIDTH:0]   chk_sum;
  logic             err_q;

  // diff + b must reconstruct a, with borrow as the carry-out.
  assign chk_sum = {1'b0, sh_nxt} + {1'b0, b_h};
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_h   <= '0;
      b_h   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_h <= a;
        b_h <= b;
      end
      if (state == RUN && last)
        err_q <= (chk_sum != {br_nxt, a_h});
      else if (state == DONE && out_ready)
        err_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_addr8u_serial_sub.sv
// Directed-vector bench for addr8u_serial_sub: table of hand-computed results plus
// handshake, backpressure, abort and (with SERSUB_CHECK_EN) fault-detect sequences.
module tb_addr8u_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, borrow;
  logic [W-1:0] diff;
`ifdef SERSUB_CHECK_EN
  logic         err;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  addr8u_serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
`ifdef SERSUB_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, d;
    logic         br;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, accept, then count edges (accepting edge included) until out_valid.
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, output int edges);
    chk("in_ready_before_accept", in_ready, 1);
    a = ia; b = ib; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb, input bit chk_lat);
    int edges;
    out_ready = 1'b1;
    start_op(ia, ib, edges);
    if (chk_lat) chk({name, "_latency"}, edges, W + 1);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_diff"}, diff, ed);
    chk({name, "_borrow"}, borrow, eb);
`ifdef SERSUB_CHECK_EN
    chk({name, "_err"}, err, 0);
`endif
    tick();
    if (chk_lat) chk({name, "_idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int edges, t0, t1;
    logic [W-1:0] ra, rb;
    logic [W:0]   rexp;

    vecs[0] = '{8'h5A, 8'h21, 8'h39, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[4] = '{8'h10, 8'h03, 8'h0D, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0};
    vecs[6] = '{8'h01, 8'h80, 8'h81, 1'b1};
    vecs[7] = '{8'h3C, 8'h3C, 8'h00, 1'b0};
    vecs[8] = '{8'hAA, 8'h55, 8'h55, 1'b0};
    vecs[9] = '{8'h55, 8'hAA, 8'hAB, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", {in_ready, out_valid, borrow, diff}, {3'b100, 8'h00});
`ifdef SERSUB_CHECK_EN
    chk("reset_err", err, 0);
`endif

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, 1'b1);

    // Random pairs against the arithmetic definition of a - b.
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rexp = {1'b0, ra} - {1'b0, rb};
      run_op("rand", ra, rb, rexp[W-1:0], rexp[W], 1'b0);
    end

    // Backpressure: result holds in DONE, new operands are refused.
    out_ready = 1'b0;
    start_op(8'hC3, 8'h4E, edges);
    chk("bp_latency", edges, W + 1);
    a = 8'h01; b = 8'h02; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {out_valid, in_ready, borrow, diff}, {3'b100, 8'h75});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release", {out_valid, in_ready}, 2'b01);
    chk("bp_diff_kept", {borrow, diff}, {1'b0, 8'h75});

    // in_valid during RUN must not disturb the accepted operands.
    a = 8'h5A; b = 8'h21; in_valid = 1'b1;
    tick();
    a = 8'hFF; b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_ignores_in", in_ready, 0);
      a = W'(i * 37 + 5); b = W'(i * 11 + 200);
    end
    edges = 0;
    while (!out_valid && edges < 40) begin tick(); edges++; end
    in_valid = 1'b0;
    chk("run_toggle_result", {out_valid, borrow, diff}, {2'b10, 8'h39});
    tick();

    // Back-to-back: in_valid held high, measure edge spacing between acceptances.
    out_ready = 1'b1; a = 8'h20; b = 8'h10; in_valid = 1'b1;
    t0 = -1; t1 = -1;
    for (int c = 0; c < 40 && t1 < 0; c++) begin
      if (in_ready) begin
        if (t0 < 0) t0 = c; else t1 = c;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("b2b_interval", t1 - t0, W + 2);
    edges = 0;
    while (!out_valid && edges < 40) begin tick(); edges++; end
    chk("b2b_result", {out_valid, borrow, diff}, {2'b10, 8'h10});
    tick();

    // Abort mid-RUN at cnt==4.
    a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_reset", {in_ready, out_valid, borrow, diff}, {3'b100, 8'h00});
    tick();
    chk("abort_no_valid", out_valid, 0);
    run_op("after_abort", 8'h10, 8'h03, 8'h0D, 1'b0, 1'b1);

`ifdef SERSUB_CHECK_EN
    // Flip one bit of the result shifter at cnt==4; it lands in diff bit 3.
    out_ready = 1'b0;
    a = 8'h5A; b = 8'h21; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    force dut.sh = dut.sh ^ 8'h80;
    #1;
    release dut.sh;
    edges = 0;
    while (!out_valid && edges < 40) begin tick(); edges++; end
    chk("fault_diff", diff, 8'h31);
    chk("fault_err", {out_valid, err}, 2'b11);
    tick();
    chk("fault_err_holds", err, 1);
    out_ready = 1'b1;
    tick();
    chk("fault_err_clear", {out_valid, err}, 2'b00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
